// File: rtl/state_reg_step.sv
// State register that loads nextS once per debounced button press, with optional auto-repeat.
// One clock domain throughout: the debounced level is only ever used as data.
module state_reg_step #(
   parameter int unsigned     WIDTH           = 4,
   parameter logic [WIDTH-1:0] RESET_STATE    = '0,
   parameter int unsigned     DEBOUNCE_CYCLES = 500000,
   parameter int unsigned     REPEAT_EN       = 0,
   parameter int unsigned     REPEAT_DELAY    = 25000000,
   parameter int unsigned     REPEAT_PERIOD   = 10000000
) (
   input  logic             clock_50MHz,
   input  logic             sync_Reset,
   input  logic             button_Step,
   input  logic [WIDTH-1:0] nextS,
   input  logic             step_Enable,
   output logic [WIDTH-1:0] sflipflop,
   output logic             step_Pulse,
   output logic             btn_Level
);

   localparam int unsigned     CntW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax    = CntW'(DEBOUNCE_CYCLES - 1);
   localparam int unsigned     RMax      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
   localparam int unsigned     RcntW     = (RMax > 1) ? $clog2(RMax) : 1;
   localparam logic [RcntW-1:0] DelayMax  = RcntW'(REPEAT_DELAY - 1);
   localparam logic [RcntW-1:0] PeriodMax = RcntW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {StIdle, StHoldDelay, StHoldRepeat} state_e;

   logic [1:0]       sync_q;
   logic             b_s;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             lvl_q, lvl_d;
   logic             lvl_prev_q;
   state_e           state_q, state_d;
   logic [RcntW-1:0] rcnt_q, rcnt_d;
   logic             fire;
   logic [WIDTH-1:0] sflipflop_q, sflipflop_d;
   logic             pulse_q, pulse_d;

   // Raw button is active-low; sync flops hold raw values, so "released" is 1.
   assign b_s = ~sync_q[1];

   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (b_s != lvl_q) begin
         if (cnt_q == CntMax) begin
            lvl_d = b_s;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      fire    = 1'b0;
      unique case (state_q)
         StIdle: begin
            rcnt_d = '0;
            if (lvl_q && !lvl_prev_q) begin
               fire = 1'b1;
               if (REPEAT_EN != 0) state_d = StHoldDelay;
            end
         end
         StHoldDelay: begin
            if (!lvl_q) begin
               state_d = StIdle;
               rcnt_d  = '0;
            end else if (rcnt_q == DelayMax) begin
               fire    = 1'b1;
               rcnt_d  = '0;
               state_d = StHoldRepeat;
            end else begin
               rcnt_d = rcnt_q + RcntW'(1);
            end
         end
         StHoldRepeat: begin
            // Release is checked first so it beats a coincident terminal count.
            if (!lvl_q) begin
               state_d = StIdle;
               rcnt_d  = '0;
            end else if (rcnt_q == PeriodMax) begin
               fire   = 1'b1;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + RcntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            rcnt_d  = '0;
         end
      endcase
   end

   // A gated-off step is dropped rather than held for later.
   always_comb begin
      sflipflop_d = sflipflop_q;
      pulse_d     = 1'b0;
      if (fire && step_Enable) begin
         sflipflop_d = nextS;
         pulse_d     = 1'b1;
      end
   end

   always_ff @(posedge clock_50MHz) begin
      if (sync_Reset) begin
         sync_q      <= 2'b11;
         cnt_q       <= '0;
         lvl_q       <= 1'b0;
         lvl_prev_q  <= 1'b0;
         state_q     <= StIdle;
         rcnt_q      <= '0;
         sflipflop_q <= RESET_STATE;
         pulse_q     <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], button_Step};
         cnt_q       <= cnt_d;
         lvl_q       <= lvl_d;
         lvl_prev_q  <= lvl_q;
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         sflipflop_q <= sflipflop_d;
         pulse_q     <= pulse_d;
      end
   end

   assign sflipflop  = sflipflop_q;
   assign step_Pulse = pulse_q;
   assign btn_Level  = lvl_q;

endmodule
